// File: rtl/sdram_ctrl_module_pkg.sv
// -----------------------------------------------------------------------------
// sdram_ctrl_module_pkg
//   Shared SDRAM definitions used by the request arbiter (sdram_ctrl_module)
//   and the SDRAM function stage it drives.
//
//   Contents:
//     - default auto-refresh interval (clk cycles at 100 MHz)
//     - bit positions of the one-hot arbiter -> function stage command bus
//     - bit positions of the user request bus
//     - arbiter state encoding
//     - SDRAM pin-level command encodings {cs_n, ras_n, cas_n, we_n}
//     - SDRAM timing constants (in clk cycles)
//     - small helpers mapping a state to its command / request bit
// -----------------------------------------------------------------------------
package sdram_ctrl_module_pkg;

  // 7.5 us at 100 MHz. Rows must be refreshed on average this often.
  localparam logic [10:0] T_REF_DEFAULT = 11'd750;

  // Width of the refresh interval counter.
  localparam int REF_CNT_W = 11;

  // One-hot command bus towards the function stage.
  localparam int CALL_W     = 5;
  localparam int CALL_INIT  = 0;
  localparam int CALL_REF   = 1;
  localparam int CALL_READ  = 2;
  localparam int CALL_WRITE = 3;
  localparam int CALL_PAGE  = 4;

  localparam logic [CALL_W-1:0] CALL_NONE     = '0;
  localparam logic [CALL_W-1:0] CALL_INIT_OH  = 5'(1) << CALL_INIT;
  localparam logic [CALL_W-1:0] CALL_REF_OH   = 5'(1) << CALL_REF;
  localparam logic [CALL_W-1:0] CALL_READ_OH  = 5'(1) << CALL_READ;
  localparam logic [CALL_W-1:0] CALL_WRITE_OH = 5'(1) << CALL_WRITE;
  localparam logic [CALL_W-1:0] CALL_PAGE_OH  = 5'(1) << CALL_PAGE;

  // User request bus (level-held until oDone).
  localparam int REQ_W     = 3;
  localparam int REQ_READ  = 0;
  localparam int REQ_WRITE = 1;
  localparam int REQ_PAGE  = 2;

  localparam logic [REQ_W-1:0] REQ_NONE     = '0;
  localparam logic [REQ_W-1:0] REQ_READ_OH  = 3'(1) << REQ_READ;
  localparam logic [REQ_W-1:0] REQ_WRITE_OH = 3'(1) << REQ_WRITE;
  localparam logic [REQ_W-1:0] REQ_PAGE_OH  = 3'(1) << REQ_PAGE;

  // Arbiter states.
  typedef enum logic [2:0] {
    INIT    = 3'd0,
    IDLE    = 3'd1,
    REFRESH = 3'd2,
    PAGE    = 3'd3,
    WRITE   = 3'd4,
    READ    = 3'd5
  } sdram_state_t;

  // SDRAM pin commands {cs_n, ras_n, cas_n, we_n}, used by the function stage.
  localparam logic [3:0] CMD_INHIBIT   = 4'b1111;
  localparam logic [3:0] CMD_NOP       = 4'b0111;
  localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
  localparam logic [3:0] CMD_READ      = 4'b0101;
  localparam logic [3:0] CMD_WRITE     = 4'b0100;
  localparam logic [3:0] CMD_BSTOP     = 4'b0110;
  localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
  localparam logic [3:0] CMD_REFRESH   = 4'b0001;
  localparam logic [3:0] CMD_LMR       = 4'b0000;

  // SDRAM timing in clk cycles at 100 MHz, used by the function stage.
  localparam int T_RP     = 2;      // precharge to next command
  localparam int T_RFC    = 7;      // refresh cycle time
  localparam int T_RCD    = 2;      // activate to read/write
  localparam int T_MRD    = 2;      // mode register set to next command
  localparam int CAS_LAT  = 3;      // read latency
  localparam int T_PWRUP  = 20000;  // 200 us power-up wait

  // Command bit raised by the arbiter while in a given state.
  function automatic logic [CALL_W-1:0] callOfState(input sdram_state_t s);
    logic [CALL_W-1:0] v;
    v = CALL_NONE;
    case (s)
      INIT:    v = CALL_INIT_OH;
      REFRESH: v = CALL_REF_OH;
      PAGE:    v = CALL_PAGE_OH;
      WRITE:   v = CALL_WRITE_OH;
      READ:    v = CALL_READ_OH;
      default: v = CALL_NONE;
    endcase
    return v;
  endfunction

  // User request bit served by a given state (zero for INIT/REFRESH/IDLE).
  function automatic logic [REQ_W-1:0] reqOfState(input sdram_state_t s);
    logic [REQ_W-1:0] v;
    v = REQ_NONE;
    case (s)
      PAGE:    v = REQ_PAGE_OH;
      WRITE:   v = REQ_WRITE_OH;
      READ:    v = REQ_READ_OH;
      default: v = REQ_NONE;
    endcase
    return v;
  endfunction

  // True for states that complete a user request.
  function automatic logic isUserState(input sdram_state_t s);
    return (s == PAGE) || (s == WRITE) || (s == READ);
  endfunction

endpackage

// File: rtl/sdram_ctrl_module.sv
// -----------------------------------------------------------------------------
// sdram_ctrl_module
//   Request arbiter in front of an SDRAM function stage. After reset it issues
//   the init command, then arbitrates between periodic auto-refresh and three
//   user requests (page read, write, single read) with fixed priority, and
//   hands exactly one one-hot command at a time to the function stage.
//
//   Parameters:
//     T_REF    auto-refresh interval in clk cycles
//   Ports:
//     clk      system clock (100 MHz)
//     rst_n    asynchronous active-low reset
//     iCall    user requests, level-held until oDone: [2] page, [1] write,
//              [0] read
//     oDone    one-cycle pulse when a granted user request completes
//     oBusy    high whenever the arbiter is not IDLE
//     oCall    one-hot command to the function stage: [4] page, [3] write,
//              [2] read, [1] refresh, [0] init
//     iDone    one-cycle completion pulse from the function stage
//     oRefOvr  sticky: a refresh interval expired with a refresh still pending
// -----------------------------------------------------------------------------
module sdram_ctrl_module
  import sdram_ctrl_module_pkg::*;
#(
  parameter logic [10:0] T_REF = T_REF_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REQ_W-1:0]  iCall,
  output logic              oDone,
  output logic              oBusy,
  output logic [CALL_W-1:0] oCall,
  input  logic              iDone,
  output logic              oRefOvr
);

  sdram_state_t         state;
  logic [REF_CNT_W-1:0] refCnt;
  logic                 refPend;
  logic [REQ_W-1:0]     doneMask;

  logic                 refWrap;
  logic                 enterRefresh;
  logic [REQ_W-1:0]     effReq;

  // The timer is frozen at zero until the init sequence has finished.
  assign refWrap      = (state != INIT) && (refCnt == (T_REF - 11'd1));
  assign enterRefresh = (state == IDLE) && refPend;

  // A requester only sees oDone after the completing edge and drops its
  // request one cycle later; mask the just-served bit during that cycle so
  // the same request is not granted a second time.
  assign effReq = iCall & ~doneMask;

  assign oBusy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= INIT;
      oCall    <= CALL_NONE;
      oDone    <= 1'b0;
      oRefOvr  <= 1'b0;
      refCnt   <= '0;
      refPend  <= 1'b0;
      doneMask <= REQ_NONE;
    end else begin
      // ---------------- refresh interval timer ----------------
      if (state != INIT) begin
        refCnt <= refWrap ? '0 : refCnt + 11'd1;
      end

      // A wrap wins over the clear on entering REFRESH: that refresh covers
      // the previous interval, the new wrap starts the next one.
      if (refWrap) begin
        refPend <= 1'b1;
      end else if (enterRefresh) begin
        refPend <= 1'b0;
      end

      if (refWrap && refPend && !enterRefresh) begin
        oRefOvr <= 1'b1;
      end

      // ---------------- command FSM ----------------
      oDone    <= 1'b0;
      doneMask <= REQ_NONE;

      case (state)
        IDLE: begin
          // iDone is deliberately not looked at here.
          if (refPend) begin
            state <= REFRESH;
            oCall <= CALL_REF_OH;
          end else if (effReq[REQ_PAGE]) begin
            state <= PAGE;
            oCall <= CALL_PAGE_OH;
          end else if (effReq[REQ_WRITE]) begin
            state <= WRITE;
            oCall <= CALL_WRITE_OH;
          end else if (effReq[REQ_READ]) begin
            state <= READ;
            oCall <= CALL_READ_OH;
          end else begin
            oCall <= CALL_NONE;
          end
        end

        default: begin
          // INIT and every command state. oCall is dropped on the very edge
          // that sees iDone; holding it one more cycle would retrigger the
          // function stage. In INIT, oCall is still zero on the first edge
          // after reset, so a stale iDone there cannot end init early.
          if (iDone && (oCall != CALL_NONE)) begin
            state <= IDLE;
            oCall <= CALL_NONE;
            if (isUserState(state)) begin
              oDone    <= 1'b1;
              doneMask <= reqOfState(state);
            end
          end else begin
            oCall <= callOfState(state);
          end
        end
      endcase
    end
  end

endmodule

// File: doc/sdram_ctrl_module.md
SDRAM_CTRL_MODULE -- requirements
Module: sdram_ctrl_module

Interface
REQ-001 SHALL have parameter T_REF, default 11'd750, giving the auto-refresh interval in clk cycles (7.5 us at 100 MHz).
REQ-002 SHALL have port clk  input  1  system clock, 100 MHz; the single clock for the block.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port iCall  input  3  user requests, level-held until oDone: [2] page read, [1] write, [0] single read.
REQ-005 SHALL have port oDone  output  1  one-cycle pulse when the granted user request completes.
REQ-006 SHALL have port oBusy  output  1  high whenever the state is not IDLE.
REQ-007 SHALL have port oCall  output  5  one-hot command to the SDRAM function stage: [4] page read, [3] write, [2] read, [1] refresh, [0] init.
REQ-008 SHALL have port iDone  input  1  one-cycle done pulse from the function stage.
REQ-009 SHALL have port oRefOvr  output  1  sticky flag: a refresh interval expired while a refresh was already pending.

Function
REQ-010 SHALL implement these states: INIT, IDLE, REFRESH, PAGE, WRITE, READ.
REQ-011 After reset, the state SHALL be INIT with oCall=5'b00001, held until iDone is sampled high.
REQ-012 In every non-IDLE state, oCall SHALL be registered, one-hot, and stable.
REQ-013 On the clk edge that samples iDone=1, the block SHALL clear oCall to 0 on that same edge and enter IDLE; it SHALL never hold oCall into the next cycle, because that would restart the function stage.
REQ-014 oCall SHALL be 0 for at least one full cycle (IDLE) between any two commands.
REQ-015 IDLE arbitration SHALL be evaluated on one edge, with fixed priority: refresh pending > iCall[2] > iCall[1] > iCall[0].
REQ-016 The grant mapping SHALL be: iCall[2]→PAGE/oCall[4], iCall[1]→WRITE/oCall[3], iCall[0]→READ/oCall[2]; a pending refresh → REFRESH/oCall[1].
REQ-017 oDone SHALL pulse for exactly one cycle, on the cycle after iDone is sampled high in PAGE, WRITE or READ.
REQ-018 oDone SHALL never pulse for INIT or REFRESH completions.
REQ-019 User requests SHALL NOT be latched; a request dropped before grant is ignored.
REQ-020 A request that is held SHALL be granted once IDLE is reached and no refresh is pending.
REQ-021 The refresh counter SHALL be 11 bits wide, held at 0 during INIT, and SHALL start counting on the first IDLE after INIT completes.
REQ-022 The refresh counter SHALL count every cycle and wrap to 0 at T_REF-1; each wrap SHALL set refPend.
REQ-023 refPend SHALL clear on the edge that enters REFRESH.
REQ-024 If a wrap occurs while refPend=1, oRefOvr SHALL set and remain set until reset.
REQ-025 If a wrap and entry into REFRESH happen on the same edge, refPend SHALL end at 1 and oRefOvr SHALL be unchanged.
REQ-026 A refresh that becomes pending during PAGE, WRITE or READ SHALL wait; it SHALL be served on the first IDLE arbitration after that operation.
REQ-027 iDone sampled in IDLE SHALL be ignored.

Reset
REQ-028 While rst_n=0, outputs SHALL be: oCall=0, oDone=0, oBusy=1, oRefOvr=0; internally, state=INIT, refresh counter=0, refPend=0.
REQ-029 On rst_n rising, oCall SHALL become 5'b00001 on the first clk edge.
REQ-030 Reset asserted mid-operation SHALL abort it; no oDone is produced and the sequence restarts with INIT.

Structure
REQ-031 The oCall bit indices, the state encodings and the default of T_REF SHALL live in a shared SDRAM package, together with the function stage's command constants.
REQ-032 The block SHALL be a single module with no sub-modules; the refresh timer is inline.

Verification
REQ-033 Release reset, return iDone 20 cycles later → oCall=00001 for those 20 cycles, then 0, then IDLE; no oDone.
REQ-034 From IDLE, iCall=3'b010, iDone 12 cycles later → oCall=01000 for 12 cycles, oDone pulse one cycle after iDone, oCall never re-asserted while iCall is held through the pulse.
REQ-035 Set iCall=3'b111 from IDLE, drop each bit on its oDone → grants in order PAGE, WRITE, READ, with one IDLE cycle between grants.
REQ-036 T_REF=16 with iCall=0 → oCall=00010 every 16 cycles, plus the refresh duration.
REQ-037 Keep refPend set and hold iCall[1] → REFRESH is granted before WRITE.
REQ-038 T_REF=16 with a 40-cycle page read → oRefOvr=1, one REFRESH served afterwards; then pulse rst_n low mid-WRITE → all outputs return to their reset values and INIT restarts.
